// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Also carries the clog2 helper used for index and counter widths.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  localparam int MAX_VAL_DEF = 9999;
  localparam int NUM_W_DEF   = 13;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_next_picker.sv
// Round-robin picker: first requester after sel, wrapping through sel.
// Purely combinational so other arbiters can reuse it.
module rr_next_picker
  import seven_seg_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int SEL_W = clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] src_req,
  input  logic [SEL_W-1:0] sel,
  output logic [SEL_W-1:0] pick,
  output logic             found
);

  // scan indices sel+1 .. sel+N_SRC (mod N_SRC), keep the first hit
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = sel;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(sel) + k) % N_SRC;
      if (!found && src_req[SEL_W'(idx)]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/seven_seg_display_scheduler.sv
// Shares one 4-digit display between N_SRC requesters.
// Auto rotation on a dwell timer or manual button stepping.
module seven_seg_display_scheduler
  import seven_seg_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int NUM_W        = NUM_W_DEF,
  parameter int MAX_VAL      = MAX_VAL_DEF,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int SEL_W        = clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC*NUM_W-1:0] src_val,
  input  logic                   manual,
  input  logic                   btn_next,
  input  logic                   freeze,
  output logic [NUM_W-1:0]       num,
  output logic [N_SRC-1:0]       grant,
  output logic [SEL_W-1:0]       sel,
  output logic                   ovf
);

  localparam int DW_W = clog2(DWELL_CYCLES + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [31:0] MAX32 = 32'(MAX_VAL);
  localparam logic [NUM_W-1:0] MAX_N = NUM_W'(MAX_VAL);
  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  state_t state, state_n;
  logic [NUM_W-1:0] num_n;
  logic [N_SRC-1:0] grant_n;
  logic [SEL_W-1:0] sel_n;
  logic ovf_n;
  logic [DW_W-1:0] dwell, dwell_n;
  logic btn_q, manual_q;
  logic step, man_chg;
  logic [SEL_W-1:0] pick;
  logic found;
  logic [NUM_W-1:0] vals [N_SRC];
  logic [NUM_W-1:0] val_sel;
  logic [31:0] val_ext;
  logic over;
  logic [NUM_W-1:0] clamped;

  rr_next_picker #(
    .N_SRC(N_SRC),
    .SEL_W(SEL_W)
  ) u_pick (
    .src_req(src_req),
    .sel    (sel),
    .pick   (pick),
    .found  (found)
  );

  // unpack the flat source bus and clamp the selected value
  always_comb begin
    for (int i = 0; i < N_SRC; i++)
      vals[i] = src_val[i*NUM_W +: NUM_W];
    val_sel = vals[sel];
    val_ext = 32'(val_sel);
    over    = val_ext > MAX32;
    clamped = over ? MAX_N : val_sel;
  end

  assign step    = btn_next & ~btn_q;
  assign man_chg = manual ^ manual_q;

  // state, output and dwell registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      num      <= '0;
      grant    <= '0;
      sel      <= SEL_W'(N_SRC - 1);
      ovf      <= 1'b0;
      dwell    <= '0;
      btn_q    <= 1'b0;
      manual_q <= 1'b0;
    end else begin
      state    <= state_n;
      num      <= num_n;
      grant    <= grant_n;
      sel      <= sel_n;
      ovf      <= ovf_n;
      dwell    <= dwell_n;
      btn_q    <= btn_next;
      manual_q <= manual;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_n = state;
    num_n   = num;
    ovf_n   = ovf;
    grant_n = grant;
    sel_n   = sel;
    dwell_n = dwell;
    unique case (state)
      IDLE: begin
        num_n   = '0;
        ovf_n   = 1'b0;
        grant_n = '0;
        if (found) begin
          state_n = SHOW;
          sel_n   = pick;
          grant_n = ONE << pick;
          dwell_n = '0;
        end
      end
      SHOW: begin
        if (!freeze) begin
          num_n = clamped;
          ovf_n = over;
        end
        if (!(|src_req)) begin
          state_n = IDLE;
          num_n   = '0;
          ovf_n   = 1'b0;
          grant_n = '0;
        end else if (!src_req[sel]) begin
          state_n = ADVANCE;
        end else if (freeze) begin
          dwell_n = dwell;
        end else if (man_chg) begin
          dwell_n = '0;
        end else if (!manual && dwell == DW_LAST) begin
          state_n = ADVANCE;
          dwell_n = '0;
        end else if (manual && step) begin
          state_n = ADVANCE;
        end else if (!manual) begin
          dwell_n = dwell + DW_W'(1);
        end
      end
      ADVANCE: begin
        if (found) begin
          state_n = SHOW;
          sel_n   = pick;
          grant_n = ONE << pick;
          dwell_n = '0;
        end else begin
          state_n = IDLE;
          num_n   = '0;
          ovf_n   = 1'b0;
          grant_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_display_scheduler.sv
// Directed scoreboard bench for seven_seg_display_scheduler.
// A 13-bit instance covers scheduling, a 14-bit one the clamp.
module tb_seven_seg_display_scheduler;

  logic clk;
  logic rst;

  logic [3:0]  src_req;
  logic [12:0] vals [4];
  logic [51:0] src_val;
  logic        manual, btn_next, freeze;
  logic [12:0] num;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        ovf;

  logic [3:0]  req14;
  logic [13:0] v14;
  logic [55:0] val14;
  logic        man14, btn14, frz14;
  logic [13:0] num14;
  logic [3:0]  grant14;
  logic [1:0]  sel14;
  logic        ovf14;

  assign src_val = {vals[3], vals[2], vals[1], vals[0]};
  assign val14   = {42'd0, v14};

  seven_seg_display_scheduler #(
    .N_SRC(4), .NUM_W(13), .MAX_VAL(9999), .DWELL_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_val(src_val),
    .manual(manual), .btn_next(btn_next), .freeze(freeze),
    .num(num), .grant(grant), .sel(sel), .ovf(ovf)
  );

  seven_seg_display_scheduler #(
    .N_SRC(4), .NUM_W(14), .MAX_VAL(9999), .DWELL_CYCLES(4)
  ) dut14 (
    .clk(clk), .rst(rst), .src_req(req14), .src_val(val14),
    .manual(man14), .btn_next(btn14), .freeze(frz14),
    .num(num14), .grant(grant14), .sel(sel14), .ovf(ovf14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic [12:0] n;
    logic [1:0]  s;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] g, input int n,
                      input logic [1:0] s, input logic o,
                      input int reps);
    exp_t e;
    e.g = g;
    e.n = 13'(n);
    e.s = s;
    e.o = o;
    for (int i = 0; i < reps; i++) sb.push_back(e);
  endtask

  task automatic step_chk(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".grant"}, 32'(grant), 32'(e.g));
      chk({tag, ".num"},   32'(num),   32'(e.n));
      chk({tag, ".sel"},   32'(sel),   32'(e.s));
      chk({tag, ".ovf"},   32'(ovf),   32'(e.o));
    end
  endtask

  task automatic run(input string tag, input int cyc);
    for (int i = 0; i < cyc; i++)
      step_chk($sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    rst = 1'b0;
    src_req = '0;
    for (int i = 0; i < 4; i++) vals[i] = '0;
    manual = 1'b0; btn_next = 1'b0; freeze = 1'b0;
    req14 = '0; v14 = '0; man14 = 1'b1; btn14 = 1'b0; frz14 = 1'b0;

    // async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst0.num",   32'(num),   0);
    chk("rst0.grant", 32'(grant), 0);
    chk("rst0.sel",   32'(sel),   3);
    chk("rst0.ovf",   32'(ovf),   0);
    chk("rst0.num14", 32'(num14), 0);
    @(negedge clk);
    rst = 1'b0;

    // idle with no requests
    push(4'b0000, 0, 3, 0, 20);
    run("idle", 20);

    // auto rotation, dwell 4
    vals[0] = 13'd1234;
    vals[2] = 13'd42;
    src_req = 4'b0101;
    push(4'b0001, 0,    0, 0, 1);
    push(4'b0001, 1234, 0, 0, 4);
    push(4'b0100, 1234, 2, 0, 1);
    push(4'b0100, 42,   2, 0, 4);
    push(4'b0001, 42,   0, 0, 1);
    push(4'b0001, 1234, 0, 0, 1);
    run("auto", 12);

    // manual toggle: no step
    manual = 1'b1;
    push(4'b0001, 1234, 0, 0, 1);
    run("mtog", 1);

    // held button gives one advance
    btn_next = 1'b1;
    push(4'b0001, 1234, 0, 0, 1);
    push(4'b0100, 1234, 2, 0, 1);
    push(4'b0100, 42,   2, 0, 8);
    run("hold", 10);
    btn_next = 1'b0;
    push(4'b0100, 42, 2, 0, 1);
    run("rel", 1);

    // second press advances again
    btn_next = 1'b1;
    push(4'b0100, 42,   2, 0, 1);
    push(4'b0001, 42,   0, 0, 1);
    push(4'b0001, 1234, 0, 0, 1);
    run("press2", 3);

    // owner drops, only source 3 left
    btn_next = 1'b0;
    src_req = 4'b1000;
    vals[3] = 13'd333;
    push(4'b0001, 1234, 0, 0, 1);
    push(4'b1000, 1234, 3, 0, 1);
    push(4'b1000, 333,  3, 0, 1);
    run("only3", 3);

    // press with a single requester re-grants it
    btn_next = 1'b1;
    push(4'b1000, 333, 3, 0, 3);
    run("regrant", 3);
    btn_next = 1'b0;

    // freeze holds the displayed value
    vals[3] = 13'd77;
    push(4'b1000, 77, 3, 0, 1);
    run("pre_frz", 1);
    freeze = 1'b1;
    vals[3] = 13'd500;
    push(4'b1000, 77, 3, 0, 2);
    run("frz", 2);
    btn_next = 1'b1;
    push(4'b1000, 77, 3, 0, 1);
    run("frz_btn", 1);

    // owner drop under freeze still advances
    vals[1] = 13'd11;
    src_req = 4'b0010;
    push(4'b1000, 77, 3, 0, 1);
    push(4'b0010, 77, 1, 0, 2);
    run("frz_drop", 3);
    freeze = 1'b0;
    push(4'b0010, 11, 1, 0, 1);
    run("unfrz", 1);

    // all requests gone
    src_req = 4'b0000;
    btn_next = 1'b0;
    push(4'b0000, 0, 1, 0, 2);
    run("to_idle", 2);

    // 14-bit instance: clamp and overflow flag
    req14 = 4'b0001;
    v14 = 14'd12000;
    @(posedge clk); #1;
    chk("c14.grant", 32'(grant14), 1);
    chk("c14.num0",  32'(num14),   0);
    @(posedge clk); #1;
    chk("c14.clamp", 32'(num14), 9999);
    chk("c14.ovf1",  32'(ovf14),  1);
    v14 = 14'd9999;
    @(posedge clk); #1;
    chk("c14.max",  32'(num14), 9999);
    chk("c14.ovf0", 32'(ovf14), 0);
    v14 = 14'd10000;
    @(posedge clk); #1;
    chk("c14.edge", 32'(num14), 9999);
    chk("c14.ovfe", 32'(ovf14), 1);

    // async reset in the middle of SHOW
    src_req = 4'b0110;
    vals[2] = 13'd42;
    push(4'b0100, 0,  2, 0, 1);
    push(4'b0100, 42, 2, 0, 1);
    run("pre_rst", 2);
    #2 rst = 1'b1;
    #1;
    chk("arst.num",   32'(num),   0);
    chk("arst.grant", 32'(grant), 0);
    chk("arst.sel",   32'(sel),   3);
    chk("arst.ovf",   32'(ovf),   0);
    chk("arst.ovf14", 32'(ovf14), 0);
    @(negedge clk);
    rst = 1'b0;
    push(4'b0010, 0,  1, 0, 1);
    push(4'b0010, 11, 1, 0, 1);
    run("post_rst", 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
